// File: rtl/pattern_serializer.sv
// ============================================================================
// Module   : pattern_serializer
// Purpose  : Valid/ready word serializer (MSB-first) with a one-word holding
//            register for gap-free streaming. Optional even-parity trailer bit
//            enabled by defining PATTERN_SER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_serializer #(
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             o_bit,
    output logic             o_valid,
    output logic             o_last,
    output logic             busy
);

    localparam int                c_CW       = $clog2(WIDTH + 2);
    localparam logic [c_CW-1:0]   c_LAST_IDX = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
`ifdef PATTERN_SER_PARITY_EN
        , S_PARITY = 2'd2
`endif
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [c_CW-1:0]  r_cnt;
`ifdef PATTERN_SER_PARITY_EN
    logic             r_par;
`endif

    logic             w_accept;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_src;

    assign w_accept = in_valid && !r_hold_full;

`ifdef PATTERN_SER_PARITY_EN
    assign w_last = (r_state == S_PARITY);
`else
    assign w_last = (r_state == S_SHIFT) && (r_cnt == c_LAST_IDX);
`endif

    // The holding register is always empty in IDLE, so it only ever feeds
    // the shifter at a word boundary; otherwise a new word goes straight in.
    assign w_load = ((r_state == S_IDLE) && w_accept) ||
                    (w_last && (r_hold_full || w_accept));
    assign w_src  = r_hold_full ? r_hold : in_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
`ifdef PATTERN_SER_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_sh    <= w_src;
                r_cnt   <= '0;
                r_state <= S_SHIFT;
`ifdef PATTERN_SER_PARITY_EN
                r_par   <= ^w_src;
`endif
            end else if (w_last) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else if (r_state == S_SHIFT) begin
                r_sh  <= r_sh << 1;
                r_cnt <= r_cnt + c_CW'(1);
`ifdef PATTERN_SER_PARITY_EN
                if (r_cnt == c_LAST_IDX) begin
                    r_state <= S_PARITY;
                end
`endif
            end

            if (w_last && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (w_accept && !w_load) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign in_ready = !r_hold_full;
    assign o_valid  = (r_state != S_IDLE);
    assign o_last   = w_last;
    assign busy     = o_valid || r_hold_full;

`ifdef PATTERN_SER_PARITY_EN
    assign o_bit = (r_state == S_SHIFT)  ? r_sh[WIDTH-1] :
                   (r_state == S_PARITY) ? r_par : 1'b0;
`else
    assign o_bit = o_valid && r_sh[WIDTH-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_serializer.sv
// ============================================================================
// Module   : tb_pattern_serializer
// Purpose  : Directed table-driven bench for pattern_serializer (WIDTH=10),
//            covering parity mode when PATTERN_SER_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pattern_serializer;

`ifdef PATTERN_SER_PARITY_EN
    localparam int c_NB = 11;
`else
    localparam int c_NB = 10;
`endif
    localparam logic [9:0] c_A   = 10'b1110011001;
    localparam logic [9:0] c_B   = 10'b0101010101;
    localparam logic [9:0] c_C   = 10'b1000000000;
    localparam logic [9:0] c_JNK = 10'b1011011110;

    logic       clock;
    logic       reset;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       o_bit;
    logic       o_valid;
    logic       o_last;
    logic       busy;

    int n_tests;
    int n_fail;

    typedef struct {
        logic       v;
        logic [9:0] d;
        logic       rdy;
        logic       ov;
        logic       ob;
        logic       ol;
        logic       bz;
    } vec_t;

    vec_t tbl[$];

    pattern_serializer #(.WIDTH(10)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .o_bit    (o_bit),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int idx, input logic rdy,
                         input logic ov, input logic ob, input logic ol,
                         input logic bz);
        n_tests++;
        if ({in_ready, o_valid, o_bit, o_last, busy} !== {rdy, ov, ob, ol, bz}) begin
            n_fail++;
            $display("FAIL %s[%0d]: got rdy/valid/bit/last/busy=%b%b%b%b%b expected %b%b%b%b%b",
                     name, idx, in_ready, o_valid, o_bit, o_last, busy,
                     rdy, ov, ob, ol, bz);
        end
    endtask

    task automatic add(input logic v, input logic [9:0] d, input logic rdy,
                       input logic ov, input logic ob, input logic ol,
                       input logic bz);
        vec_t e;
        e.v = v; e.d = d; e.rdy = rdy; e.ov = ov; e.ob = ob; e.ol = ol; e.bz = bz;
        tbl.push_back(e);
    endtask

    function automatic logic exp_bit(input logic [9:0] w, input int k);
        exp_bit = (k < 10) ? w[9-k] : ^w;
    endfunction

    // Expected output cycles of one word. fv: offer nd on the first bit
    // cycle (it will be held); lv: offer nd on the last bit cycle.
    task automatic word_bits(input logic [9:0] w, input logic fv,
                             input logic lv, input logic [9:0] nd);
        for (int k = 0; k < c_NB; k++) begin
            logic last;
            logic give;
            last = (k == c_NB - 1);
            give = (fv && k == 0) || (lv && last);
            add(give, give ? nd : c_JNK, (k == 0) ? 1'b1 : !fv,
                1'b1, exp_bit(w, k), last, 1'b1);
        end
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            check(name, i, tbl[i].rdy, tbl[i].ov, tbl[i].ob, tbl[i].ol, tbl[i].bz);
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
        end
        tbl.delete();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("in_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Idle, single word, then data changes after acceptance are ignored
        for (int i = 0; i < 5; i++) add(1'b0, c_JNK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, c_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        word_bits(c_A, 1'b0, 1'b0, '0);
        add(1'b0, c_JNK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, c_JNK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("single");

        // Back-to-back through the holding register
        add(1'b1, c_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        word_bits(c_A, 1'b1, 1'b0, c_B);
        word_bits(c_B, 1'b0, 1'b0, '0);
        add(1'b0, c_JNK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("b2b");

        // Word offered only on the last-bit cycle goes straight to the shifter
        add(1'b1, c_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        word_bits(c_A, 1'b0, 1'b1, c_B);
        word_bits(c_B, 1'b0, 1'b0, '0);
        add(1'b0, c_JNK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("lastacc");

`ifdef PATTERN_SER_PARITY_EN
        add(1'b1, c_C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        word_bits(c_C, 1'b0, 1'b0, '0);
        add(1'b0, c_JNK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("parity");
`else
        add(1'b1, c_C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        word_bits(c_C, 1'b0, 1'b0, '0);
        add(1'b0, c_JNK, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("msbonly");
`endif

        // Reset on the 4th bit of A with B held: both words discarded
        @(negedge clock);
        in_valid = 1'b1; in_data = c_A;
        @(negedge clock);
        check("rst_seq", 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        in_data = c_B;
        @(negedge clock);
        check("rst_seq", 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0; in_data = c_JNK;
        @(negedge clock);
        check("rst_seq", 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        check("rst_seq", 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1; in_valid = 1'b1;
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
        check("rst_after", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 25; i++) begin
            @(negedge clock);
            check("rst_after", i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset wins over a simultaneous accept
        reset = 1'b1; in_valid = 1'b1; in_data = c_A;
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b0;
        check("rst_prio", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check("rst_prio", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
